// File: rtl/elbeth_mem_pkg.sv
// rtl/elbeth_mem_pkg.sv - size encodings, mcause codes and FSM states shared by the elbeth memory port
package elbeth_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] EXC_IF_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_IF_FAULT    = 4'd1;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic [3:0] exc_code(input logic is_data, input logic we, input logic fault);
        if (!is_data) return fault ? EXC_IF_FAULT : EXC_IF_MISALIGN;
        if (we)       return fault ? EXC_ST_FAULT : EXC_ST_MISALIGN;
        return fault ? EXC_LD_FAULT : EXC_LD_MISALIGN;
    endfunction

endpackage

// File: rtl/elbeth_mem_lane_align.sv
// rtl/elbeth_mem_lane_align.sv - byte strobes, lane-replicated store data and misalignment flag
module elbeth_mem_lane_align
    import elbeth_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = (i_addr_lo != 2'b00);
        case (i_size)
            SZ_BYTE: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wdata[7:0]}};
                o_misaligned = 1'b0;
            end
            SZ_HALF: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            SZ_WORD: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/elbeth_mem_port.sv
// rtl/elbeth_mem_port.sv - single-channel CPU-to-memory port with alignment/range checks
// Optional response watchdog built when ELBETH_MEM_TIMEOUT_EN is defined.
module elbeth_mem_port
    import elbeth_mem_pkg::*;
#(
    parameter int IS_DATA = 1,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_exc,
    output logic [3:0]        cpu_exc_code,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_error
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("elbeth_mem_port: TIMEOUT must be within 1..65535");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic [31:0]         r_rdata;
    logic [3:0]          r_code;

    logic                w_we;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata_rep;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_timeout;
    logic                w_load;
    logic                w_set_code;
    logic [3:0]          w_code;

    assign w_we           = (IS_DATA != 0) && cpu_we;
    assign w_out_of_range = (cpu_addr >> (ADDR_W + 2)) != 32'd0;

    elbeth_mem_lane_align u_align (
        .i_size       (cpu_size),
        .i_addr_lo    (cpu_addr[1:0]),
        .i_wdata      (cpu_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
        .o_misaligned (w_misaligned)
    );

`ifdef ELBETH_MEM_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_wait_cnt <= 16'd0;
        else if (r_state != ST_WAIT) r_wait_cnt <= 16'd0;
        else                        r_wait_cnt <= r_wait_cnt + 16'd1;
    end

    // The count reads TIMEOUT-1 during the TIMEOUT-th WAIT cycle.
    assign w_timeout = (r_wait_cnt == 16'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_set_code   = 1'b0;
        w_code       = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (w_misaligned) begin
                        w_state_next = ST_ERR;
                        w_set_code   = 1'b1;
                        w_code       = exc_code(IS_DATA != 0, w_we, 1'b0);
                    end else if (w_out_of_range) begin
                        w_state_next = ST_ERR;
                        w_set_code   = 1'b1;
                        w_code       = exc_code(IS_DATA != 0, w_we, 1'b1);
                    end else begin
                        w_state_next = ST_WAIT;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A fault reported alongside mem_ready still counts as a fault.
                if (mem_error || (!mem_ready && w_timeout)) begin
                    w_state_next = ST_ERR;
                    w_set_code   = 1'b1;
                    w_code       = exc_code(IS_DATA != 0, r_we, 1'b1);
                end else if (mem_ready) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            ST_ERR:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_rdata <= 32'd0;
            r_code  <= 4'd0;
        end else begin
            if (w_load) begin
                r_addr  <= cpu_addr[ADDR_W+1:2];
                r_we    <= w_we;
                r_be    <= w_we ? w_be : 4'b0000;
                r_wdata <= w_we ? w_wdata_rep : 32'd0;
            end
            if (w_set_code) r_code <= w_code;
            if (r_state == ST_WAIT && w_state_next == ST_DONE) r_rdata <= mem_rdata;
        end
    end

    assign mem_en       = (r_state == ST_WAIT);
    assign mem_addr     = r_addr;
    assign mem_be       = r_be;
    assign mem_wdata    = r_wdata;
    assign cpu_ready    = (r_state == ST_DONE) || (r_state == ST_ERR);
    assign cpu_exc      = (r_state == ST_ERR);
    assign cpu_exc_code = (r_state == ST_ERR) ? r_code : 4'd0;
    assign cpu_rdata    = r_rdata;

endmodule

// File: tb/tb_elbeth_mem_port.sv
// tb/tb_elbeth_mem_port.sv - directed self-checking bench for elbeth_mem_port (data and fetch channels)
module tb_elbeth_mem_port;
    import elbeth_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready, mem_error;

    logic [31:0] cpu_rdata, mem_wdata;
    logic        cpu_ready, cpu_exc, mem_en;
    logic [3:0]  cpu_exc_code, mem_be;
    logic [7:0]  mem_addr;

    logic        f_req, f_mem_ready, f_mem_error;
    logic [31:0] f_cpu_rdata, f_mem_wdata;
    logic        f_cpu_ready, f_cpu_exc, f_mem_en;
    logic [3:0]  f_cpu_exc_code, f_mem_be;
    logic [7:0]  f_mem_addr;

    int checks = 0;
    int errors = 0;

    elbeth_mem_port #(.IS_DATA(1), .ADDR_W(8), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_exc(cpu_exc), .cpu_exc_code(cpu_exc_code),
        .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error)
    );

    elbeth_mem_port #(.IS_DATA(0), .ADDR_W(8), .TIMEOUT(4)) u_ifu (
        .clk(clk), .rst(rst),
        .cpu_req(f_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(f_cpu_rdata), .cpu_ready(f_cpu_ready),
        .cpu_exc(f_cpu_exc), .cpu_exc_code(f_cpu_exc_code),
        .mem_en(f_mem_en), .mem_be(f_mem_be), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(f_mem_ready), .mem_error(f_mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        cpu_we = we; cpu_size = sz; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    endtask

    task automatic test_reset;
        checks++; if ({cpu_ready, cpu_exc, cpu_exc_code, mem_en, mem_be} !== 11'd0) begin
            errors++; $display("FAIL reset_ctrl got %h want 000", {cpu_ready, cpu_exc, cpu_exc_code, mem_en, mem_be}); end
        checks++; if ({mem_addr, mem_wdata, cpu_rdata} !== 72'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, cpu_rdata}); end
        checks++; if ({f_cpu_ready, f_mem_en} !== 2'b00) begin
            errors++; $display("FAIL reset_ifu got %b want 00", {f_cpu_ready, f_mem_en}); end
    endtask

    task automatic test_word_load;
        issue(1'b0, SZ_WORD, 32'h10, 32'h0);
        tick;
        checks++; if ({mem_en, mem_be} !== 5'b1_0000) begin
            errors++; $display("FAIL ld_c1_en_be got %b want 10000", {mem_en, mem_be}); end
        checks++; if (mem_addr !== 8'h04) begin
            errors++; $display("FAIL ld_mem_addr got %h want 04", mem_addr); end
        tick;
        tick;
        checks++; if (cpu_ready !== 1'b0) begin
            errors++; $display("FAIL ld_c3_ready got %b want 0", cpu_ready); end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        mem_ready = 1'b0; mem_rdata = 32'h0; cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc, mem_en} !== 3'b100) begin
            errors++; $display("FAIL ld_c4_ready got %b want 100", {cpu_ready, cpu_exc, mem_en}); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL ld_rdata got %h want deadbeef", cpu_rdata); end
        tick;
        checks++; if ({cpu_ready, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL ld_hold got %h want 0deadbeef", {cpu_ready, cpu_rdata}); end
    endtask

    task automatic test_stores;
        issue(1'b1, SZ_BYTE, 32'h23, 32'h000000A5);
        tick;
        checks++; if ({mem_en, mem_be, mem_addr} !== {1'b1, 4'b1000, 8'h08}) begin
            errors++; $display("FAIL sb_ctrl got %h want 1808", {mem_en, mem_be, mem_addr}); end
        checks++; if (mem_wdata !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", mem_wdata); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0; cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc} !== 2'b10) begin
            errors++; $display("FAIL sb_best_case got %b want 10", {cpu_ready, cpu_exc}); end
        tick;
        issue(1'b1, SZ_HALF, 32'h22, 32'h1234BEEF);
        tick;
        checks++; if ({mem_be, mem_addr, mem_wdata} !== {4'b1100, 8'h08, 32'hBEEFBEEF}) begin
            errors++; $display("FAIL sh got %h want c08beefbeef", {mem_be, mem_addr, mem_wdata}); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0; cpu_req = 1'b0;
        tick;
        issue(1'b1, SZ_WORD, 32'h0C, 32'h11223344);
        tick;
        checks++; if ({mem_be, mem_addr, mem_wdata} !== {4'b1111, 8'h03, 32'h11223344}) begin
            errors++; $display("FAIL sw got %h want f0311223344", {mem_be, mem_addr, mem_wdata}); end
        mem_error = 1'b1;
        tick;
        mem_error = 1'b0; cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc, cpu_exc_code, mem_en} !== {2'b11, 4'd7, 1'b0}) begin
            errors++; $display("FAIL sw_fault got %b want 1101110", {cpu_ready, cpu_exc, cpu_exc_code, mem_en}); end
        tick;
        issue(1'b0, SZ_BYTE, 32'h01, 32'hFFFFFFFF);
        tick;
        checks++; if ({mem_en, mem_be, mem_addr} !== {1'b1, 4'b0000, 8'h00}) begin
            errors++; $display("FAIL lb_read_be got %h want 1000", {mem_en, mem_be, mem_addr}); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0; cpu_req = 1'b0;
        tick;
    endtask

    task automatic test_rejects;
        issue(1'b0, SZ_WORD, 32'h12, 32'h0);
        tick;
        cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc, cpu_exc_code, mem_en} !== {2'b11, 4'd4, 1'b0}) begin
            errors++; $display("FAIL lw_misalign got %b want 1101000", {cpu_ready, cpu_exc, cpu_exc_code, mem_en}); end
        tick;
        issue(1'b1, SZ_HALF, 32'h31, 32'h0);
        tick;
        cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc, cpu_exc_code, mem_en} !== {2'b11, 4'd6, 1'b0}) begin
            errors++; $display("FAIL sh_misalign got %b want 1101100", {cpu_ready, cpu_exc, cpu_exc_code, mem_en}); end
        tick;
        issue(1'b1, SZ_WORD, 32'h400, 32'h0);
        tick;
        cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc, cpu_exc_code, mem_en} !== {2'b11, 4'd7, 1'b0}) begin
            errors++; $display("FAIL sw_range got %b want 1101110", {cpu_ready, cpu_exc, cpu_exc_code, mem_en}); end
        tick;
        issue(1'b0, SZ_WORD, 32'h402, 32'h0);
        tick;
        cpu_req = 1'b0;
        checks++; if (cpu_exc_code !== 4'd4) begin
            errors++; $display("FAIL misalign_over_range got %0d want 4", cpu_exc_code); end
        tick;
        issue(1'b0, SZ_WORD, 32'h3FC, 32'h0);
        tick;
        checks++; if ({mem_en, mem_addr} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL top_word got %h want 1ff", {mem_en, mem_addr}); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0; cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc} !== 2'b10) begin
            errors++; $display("FAIL top_word_done got %b want 10", {cpu_ready, cpu_exc}); end
        tick;
    endtask

    task automatic test_fetch;
        cpu_we = 1'b1; cpu_size = SZ_WORD; cpu_addr = 32'h20; cpu_wdata = 32'h55555555; f_req = 1'b1;
        tick;
        checks++; if ({f_mem_en, f_mem_be, f_mem_addr} !== {1'b1, 4'b0000, 8'h08}) begin
            errors++; $display("FAIL if_req got %h want 1008", {f_mem_en, f_mem_be, f_mem_addr}); end
        checks++; if (mem_en !== 1'b0) begin
            errors++; $display("FAIL if_data_idle got %b want 0", mem_en); end
        f_mem_error = 1'b1; f_mem_ready = 1'b1;
        tick;
        f_mem_error = 1'b0; f_mem_ready = 1'b0; f_req = 1'b0;
        checks++; if ({f_cpu_ready, f_cpu_exc, f_cpu_exc_code, f_mem_en} !== {2'b11, 4'd1, 1'b0}) begin
            errors++; $display("FAIL if_fault got %b want 1100010", {f_cpu_ready, f_cpu_exc, f_cpu_exc_code, f_mem_en}); end
        tick;
        cpu_addr = 32'h22; f_req = 1'b1;
        tick;
        f_req = 1'b0;
        checks++; if ({f_cpu_ready, f_cpu_exc, f_cpu_exc_code} !== {2'b11, 4'd0}) begin
            errors++; $display("FAIL if_misalign got %b want 110000", {f_cpu_ready, f_cpu_exc, f_cpu_exc_code}); end
        cpu_we = 1'b0;
        tick;
    endtask

    task automatic test_reset_in_wait;
        issue(1'b0, SZ_WORD, 32'h40, 32'h0);
        tick;
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0) begin
            errors++; $display("FAIL rst_async_mem_en got %b want 0", mem_en); end
        cpu_req = 1'b0;
        tick;
        tick;
        checks++; if ({cpu_ready, mem_en, cpu_rdata} !== 34'd0) begin
            errors++; $display("FAIL rst_no_pulse got %h want 0", {cpu_ready, mem_en, cpu_rdata}); end
        rst = 1'b1;
        tick;
        issue(1'b0, SZ_WORD, 32'h44, 32'h0);
        tick;
        checks++; if ({mem_en, mem_addr} !== {1'b1, 8'h11}) begin
            errors++; $display("FAIL rst_after_req got %h want 111", {mem_en, mem_addr}); end
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick;
        mem_ready = 1'b0; cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc, cpu_rdata} !== {2'b10, 32'hCAFEF00D}) begin
            errors++; $display("FAIL rst_after_done got %h want 2cafef00d", {cpu_ready, cpu_exc, cpu_rdata}); end
        tick;
    endtask

    task automatic test_drop_req;
        issue(1'b0, SZ_WORD, 32'h08, 32'h0);
        tick;
        cpu_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        tick;
        mem_ready = 1'b0;
        checks++; if ({cpu_ready, cpu_rdata} !== {1'b1, 32'h0BADF00D}) begin
            errors++; $display("FAIL drop_req got %h want 10badf00d", {cpu_ready, cpu_rdata}); end
        tick;
    endtask

    task automatic test_back_to_back;
        issue(1'b0, SZ_WORD, 32'h00, 32'h0);
        tick;
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        tick;
        mem_ready = 1'b0; cpu_addr = 32'h04;
        checks++; if (cpu_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first_ready got %b want 1", cpu_ready); end
        tick;
        checks++; if (mem_en !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got %b want 0", mem_en); end
        tick;
        checks++; if ({mem_en, mem_addr} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL b2b_second got %h want 101", {mem_en, mem_addr}); end
        mem_ready = 1'b1; mem_rdata = 32'h22222222; cpu_req = 1'b0;
        tick;
        mem_ready = 1'b0;
        checks++; if ({cpu_ready, cpu_rdata} !== {1'b1, 32'h22222222}) begin
            errors++; $display("FAIL b2b_second_done got %h want 122222222", {cpu_ready, cpu_rdata}); end
        tick;
    endtask

    task automatic test_timeout;
        int n;
        logic saw_ready;
        issue(1'b0, SZ_WORD, 32'h50, 32'h0);
        tick;
`ifdef ELBETH_MEM_TIMEOUT_EN
        n = 0;
        while (mem_en && n < 20) begin
            n++;
            tick;
        end
        cpu_req = 1'b0;
        checks++; if (n !== 4) begin
            errors++; $display("FAIL to_en_cycles got %0d want 4", n); end
        checks++; if ({cpu_ready, cpu_exc, cpu_exc_code} !== {2'b11, 4'd5}) begin
            errors++; $display("FAIL to_fault got %b want 110101", {cpu_ready, cpu_exc, cpu_exc_code}); end
        tick;
`else
        saw_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            saw_ready = saw_ready | cpu_ready;
            tick;
        end
        checks++; if ({mem_en, saw_ready} !== 2'b10) begin
            errors++; $display("FAIL no_to_wait got %b want 10", {mem_en, saw_ready}); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0; cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_exc} !== 2'b10) begin
            errors++; $display("FAIL no_to_done got %b want 10", {cpu_ready, cpu_exc}); end
        tick;
`endif
    endtask

    initial begin
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = SZ_WORD; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0; mem_error = 1'b0;
        f_req = 1'b0; f_mem_ready = 1'b0; f_mem_error = 1'b0;
        tick;
        tick;
        test_reset;
        rst = 1'b1;
        tick;
        test_word_load;
        test_stores;
        test_rejects;
        test_fetch;
        test_reset_in_wait;
        test_drop_req;
        test_back_to_back;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
